// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Free-running raster timing generator (counters, sync, blank,
//               frame_start). Optional frame_cnt port via VGA_FRAME_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE     = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_LEN   = 128,
    parameter int H_TOTAL      = 1056,
    parameter int V_ACTIVE     = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_LEN   = 4,
    parameter int V_TOTAL      = 628
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [11:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [11:0] vcount,
    output logic        vsync,
    output logic        vblnk,
`ifdef VGA_FRAME_COUNTER_EN
    output logic        frame_start,
    output logic [15:0] frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    // Thresholds are 13 bits so a sync window ending exactly at 4096 still compares correctly.
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_SYNC_START);
    localparam logic [12:0] HS_END = 13'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG = 13'(V_SYNC_START);
    localparam logic [12:0] VS_END = 13'(V_SYNC_START + V_SYNC_LEN);

    logic [11:0] hcount_q, hcount_d;
    logic [11:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic        h_wrap;
    logic        v_wrap;
    logic [12:0] h_next;
    logic [12:0] v_next;

    always_comb begin
        h_wrap        = (hcount_q == H_LAST);
        v_wrap        = (vcount_q == V_LAST);
        hcount_d      = h_wrap ? 12'd0 : hcount_q + 12'd1;
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d  = v_wrap ? 12'd0 : vcount_q + 12'd1;
        end
        frame_start_d = h_wrap && v_wrap;
        // Flags decoded from the next count so they line up with the registered counts.
        h_next        = {1'b0, hcount_d};
        v_next        = {1'b0, vcount_d};
        hblnk_d       = (h_next >= H_ACT);
        hsync_d       = (h_next >= HS_BEG) && (h_next < HS_END);
        vblnk_d       = (v_next >= V_ACT);
        vsync_d       = (v_next >= VS_BEG) && (v_next < VS_END);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= 12'd0;
            vcount_q      <= 12'd0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            hblnk_q       <= hblnk_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign hblnk       = hblnk_q;
    assign vsync       = vsync_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
